// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared types and sizing helpers for the width-conversion FIFO blocks.
//   - unpack_state_t : drain-stage state (IDLE: no word held, SEND: word held)
//   - word_width()   : FIFO word width for a given ratio and beat width
//   - idx_width()    : width of a beat index counting 0..ratio-1
package fifo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } unpack_state_t;

   function automatic int word_width(input int ratio, input int data_width);
      return ratio * data_width;
   endfunction

   // Never returns 0, so a beat index always has at least one bit.
   function automatic int idx_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker
//   Drains wide words from a first-word-fall-through FIFO read port and
//   emits each one as RATIO narrow beats on a valid/ready stream. The
//   stream runs at one beat per cycle, including across word boundaries.
//
// Parameters
//   DATA_WIDTH : width of one output beat
//   RATIO      : beats per FIFO word (>= 2)
//   MSB_FIRST  : nonzero -> highest slice first, 0 -> lowest slice first
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   empty_i  : FIFO empty flag, rdata_i is valid while low
//   rdata_i  : FIFO head word (RATIO*DATA_WIDTH bits)
//   rd_o     : FIFO pop strobe, one cycle per word
//   data_o   : current output beat
//   valid_o  : data_o valid
//   ready_i  : consumer accepts the beat when valid_o && ready_i
//   busy_o   : a word is held (same as valid_o)
//
// Handshake: a beat transfers on a rising edge where valid_o && ready_i.
// valid_o comes straight from the state register, never from ready_i, and
// while valid_o && !ready_i both valid_o and data_o hold stable.
module fifo_word_unpacker
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 2,
   parameter int MSB_FIRST  = 1
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic                                       empty_i,
   input  logic [word_width(RATIO, DATA_WIDTH)-1:0]   rdata_i,
   output logic                                       rd_o,
   output logic [DATA_WIDTH-1:0]                      data_o,
   output logic                                       valid_o,
   input  logic                                       ready_i,
   output logic                                       busy_o
);

   localparam int WW = word_width(RATIO, DATA_WIDTH);
   localparam int IW = idx_width(RATIO);
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   unpack_state_t r_state;
   unpack_state_t w_state_nxt;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_idx_nxt;
   logic [WW-1:0] r_hold;
   logic          w_load;
   logic          w_last_taken;
   logic [IW-1:0] w_sel;
   logic [RATIO-1:0][DATA_WIDTH-1:0] w_slices;

   // The final beat being accepted frees the hold register in the same
   // cycle, so the next word can be popped without a bubble.
   assign w_last_taken = (r_state == SEND) && (r_idx == LAST_IDX) && ready_i;
   assign w_load       = !empty_i && ((r_state == IDLE) || w_last_taken);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (w_load) begin
         w_state_nxt = SEND;
         w_idx_nxt   = '0;
      end else if (r_state == SEND && ready_i) begin
         if (r_idx == LAST_IDX) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
         end else begin
            w_idx_nxt = r_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_load) begin
            r_hold <= rdata_i;
         end
      end
   end

   // Slice k of the held word is bits [k*DATA_WIDTH +: DATA_WIDTH].
   assign w_slices = r_hold;
   assign w_sel    = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;

   // Gate with reset so the FIFO is never popped while held in reset.
   assign rd_o    = rst_ni & w_load;
   assign data_o  = w_slices[w_sel];
   assign valid_o = (r_state == SEND);
   assign busy_o  = (r_state == SEND);

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb_fifo_word_unpacker
//   Bench for fifo_word_unpacker. One instance uses the default
//   configuration (8-bit beats, 2 per word, MSB first); a second one uses
//   4 beats per word, LSB first. The FIFO is modelled as a queue of words,
//   and every popped word is expanded into its expected beat order.
module tb_fifo_word_unpacker;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT: RATIO=2, MSB first ----------------
   logic        empty_i = 1'b1;
   logic [15:0] rdata_i = '0;
   logic        ready_i = 1'b0;
   logic        rd_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        busy_o;

   fifo_word_unpacker #(.DATA_WIDTH(8), .RATIO(2), .MSB_FIRST(1)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .empty_i (empty_i),
      .rdata_i (rdata_i),
      .rd_o    (rd_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .busy_o  (busy_o)
   );

   // ---------------- DUT: RATIO=4, LSB first ----------------
   logic        empty4 = 1'b1;
   logic [31:0] rdata4 = '0;
   logic        ready4 = 1'b0;
   logic        rd4;
   logic [7:0]  data4;
   logic        valid4;
   logic        busy4;

   fifo_word_unpacker #(.DATA_WIDTH(8), .RATIO(4), .MSB_FIRST(0)) dut4 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .empty_i (empty4),
      .rdata_i (rdata4),
      .rd_o    (rd4),
      .data_o  (data4),
      .valid_o (valid4),
      .ready_i (ready4),
      .busy_o  (busy4)
   );

   // ---------------- scoreboard ----------------
   logic [15:0] fifo_q[$];   // words waiting in the modelled FIFO
   logic [7:0]  exp_q[$];    // beats of popped words, not yet accepted
   logic [7:0]  got_q[$];    // beats accepted in the current sequence
   int          acc_cyc[$];  // cycle numbers of those acceptances
   int          total = 0;
   int          bad   = 0;
   int          rd_cnt = 0;
   int          cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive the FIFO head and ready, then check outputs
   // against the model before the rising edge.
   task automatic step(input logic rdy);
      logic exp_rd;
      logic [15:0] w;
      @(negedge clk);
      ready_i = rdy;
      empty_i = (fifo_q.size() == 0);
      rdata_i = empty_i ? 16'($urandom) : fifo_q[0];
      #2;
      // A word is pulled only when nothing will remain held after this cycle.
      exp_rd = !empty_i && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
      check("valid", {31'd0, valid_o}, {31'd0, exp_q.size() != 0});
      check("busy",  {31'd0, busy_o},  {31'd0, exp_q.size() != 0});
      check("rd",    {31'd0, rd_o},    {31'd0, exp_rd});
      if (valid_o && exp_q.size() != 0) begin
         if (rdy) begin
            check("beat", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
            got_q.push_back(data_o);
            acc_cyc.push_back(cyc);
         end else begin
            check("stall_data", {24'd0, data_o}, {24'd0, exp_q[0]});
         end
      end
      if (rd_o && !empty_i) begin
         w = fifo_q.pop_front();
         for (int i = 0; i < 2; i++) begin
            exp_q.push_back(w[15:8]);
            w = w << 8;
         end
         rd_cnt++;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic start_seq();
      got_q.delete();
      acc_cyc.delete();
      rd_cnt = 0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] word;
      logic [7:0]  b0;
      logic [7:0]  b1;
   } vec_t;
   vec_t vecs[4];

   logic [7:0] exp4[4];
   int guard;

   initial begin
      vecs[0] = '{word: 16'hABCD, b0: 8'hAB, b1: 8'hCD};
      vecs[1] = '{word: 16'h0102, b0: 8'h01, b1: 8'h02};
      vecs[2] = '{word: 16'hFF00, b0: 8'hFF, b1: 8'h00};
      vecs[3] = '{word: 16'h8001, b0: 8'h80, b1: 8'h01};
      exp4[0] = 8'h44; exp4[1] = 8'h33; exp4[2] = 8'h22; exp4[3] = 8'h11;

      // ---- reset values (FIFO shows data so a pop would be possible) ----
      empty_i = 1'b0;
      rdata_i = 16'hABCD;
      ready_i = 1'b1;
      #3;
      check("rst_rd",    {31'd0, rd_o},    32'd0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o},  32'd0);
      check("rst_data",  {24'd0, data_o},  32'd0);
      check("rst_rd4",   {31'd0, rd4},     32'd0);
      #20;
      @(negedge clk);
      empty_i = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);

      // ---- table: single words, ready held high ----
      for (int v = 0; v < 4; v++) begin
         start_seq();
         fifo_q.push_back(vecs[v].word);
         repeat (4) step(1'b1);
         check("tbl_count", got_q.size(), 32'd2);
         check("tbl_b0", {24'd0, got_q[0]}, {24'd0, vecs[v].b0});
         check("tbl_b1", {24'd0, got_q[1]}, {24'd0, vecs[v].b1});
         check("tbl_rd", rd_cnt, 32'd1);
         check("tbl_gap", acc_cyc[1] - acc_cyc[0], 32'd1);
      end

      // ---- backpressure: 3 stalled cycles on the first beat ----
      start_seq();
      fifo_q.push_back(16'hABCD);
      step(1'b1);
      repeat (3) begin
         step(1'b0);
         check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
         check("bp_hold_data", {24'd0, data_o}, 32'h0000_00AB);
      end
      repeat (3) step(1'b1);
      check("bp_count", got_q.size(), 32'd2);
      check("bp_b0", {24'd0, got_q[0]}, 32'h0000_00AB);
      check("bp_b1", {24'd0, got_q[1]}, 32'h0000_00CD);
      check("bp_rd", rd_cnt, 32'd1);

      // ---- streaming: three words back to back, no bubbles ----
      start_seq();
      fifo_q.push_back(16'h0102);
      fifo_q.push_back(16'h0304);
      fifo_q.push_back(16'h0506);
      repeat (9) step(1'b1);
      check("st_count", got_q.size(), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check("st_beat", {24'd0, got_q[i]}, 32'(i + 1));
      end
      check("st_span", acc_cyc[5] - acc_cyc[0], 32'd5);
      check("st_rd", rd_cnt, 32'd3);

      // ---- async reset between the two beats ----
      start_seq();
      fifo_q.push_back(16'hABCD);
      step(1'b1);
      step(1'b1);
      check("ar_first", {24'd0, got_q[0]}, 32'h0000_00AB);
      @(negedge clk);
      empty_i = 1'b0;
      rdata_i = 16'h5A5A;
      ready_i = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_valid", {31'd0, valid_o}, 32'd0);
      check("ar_busy",  {31'd0, busy_o},  32'd0);
      check("ar_data",  {24'd0, data_o},  32'd0);
      check("ar_rd",    {31'd0, rd_o},    32'd0);
      exp_q.delete();
      @(negedge clk);
      empty_i = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      repeat (4) step(1'b1);
      check("ar_no_repop", rd_cnt, 32'd1);

      // ---- empty guard: ready toggles, nothing may happen ----
      start_seq();
      for (int i = 0; i < 10; i++) step(1'(i % 2));
      check("eg_rd", rd_cnt, 32'd0);
      check("eg_beats", got_q.size(), 32'd0);

      // ---- randomized traffic against the queue model ----
      start_seq();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4)
            fifo_q.push_back(16'($urandom));
         step($urandom_range(0, 3) != 0);
      end
      guard = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && guard < 50) begin
         step(1'b1);
         guard++;
      end
      check("rnd_drained", fifo_q.size() + exp_q.size(), 32'd0);
      check("rnd_beats", got_q.size(), 32'(2 * rd_cnt));

      // ---- RATIO=4, LSB first ----
      @(negedge clk);
      empty4 = 1'b0;
      rdata4 = 32'h11223344;
      ready4 = 1'b1;
      #2;
      check("r4_rd", {31'd0, rd4}, 32'd1);
      check("r4_valid0", {31'd0, valid4}, 32'd0);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         empty4 = 1'b1;
         rdata4 = 32'hDEADBEEF;
         #2;
         check("r4_valid", {31'd0, valid4}, 32'd1);
         check("r4_beat", {24'd0, data4}, {24'd0, exp4[i]});
         check("r4_no_rd", {31'd0, rd4}, 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      #2;
      check("r4_idle", {31'd0, valid4}, 32'd0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_word_unpacker.md
# fifo_word_unpacker

Downstream drain stage for the width-conversion FIFO: pops wide words (RATIO × DATA_WIDTH bits) from the FIFO's first-word-fall-through read port. Emits each word as RATIO narrow beats on a valid/ready stream, most-significant slice first. Sits between the FIFO read side and the narrow consumer, for example a byte serializer or a display/UART sender. Sustains one narrow beat per cycle, including across word boundaries.

## Interface
- DATA_WIDTH, 8, width of one output beat
- RATIO, 2, output beats per FIFO word (≥2); FIFO word width = RATIO*DATA_WIDTH
- MSB_FIRST, 1, 1: highest slice emitted first; 0: lowest slice first

- clk_i  input  1  single clock, all logic rising-edge
- rst_ni  input  1  asynchronous active-low reset
- empty_i  input  1  FIFO empty flag; rdata_i valid when low
- rdata_i  input  RATIO*DATA_WIDTH  FIFO head word (first-word-fall-through)
- rd_o  output  1  pop strobe to FIFO, one cycle per word
- data_o  output  DATA_WIDTH  current output beat
- valid_o  output  1  data_o valid
- ready_i  input  1  consumer accepts beat when valid_o && ready_i
- busy_o  output  1  a word is held (valid_o alias, kept for status LEDs)

## Operation
- State machine, two states:
  - IDLE: no word held.
  - SEND: word held in hold register, beat index idx in 0..RATIO-1.
- Load condition: `load = !empty_i && (state==IDLE || (state==SEND && idx==RATIO-1 && ready_i))`.
- `rd_o = load`, combinational. rd_o is forced 0 while rst_ni is low.
- On load:
  - hold register ← rdata_i, idx ← 0, state ← SEND.
- In SEND with ready_i high and idx < RATIO-1:
  - idx ← idx+1.
- In SEND with ready_i high, idx == RATIO-1 and empty_i high:
  - state ← IDLE.
- In SEND with ready_i low: no change.
- Beat selection:
  - data_o = slice (RATIO-1-idx) of the hold register if MSB_FIRST, otherwise slice idx.
  - Slice k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_o = busy_o = (state==SEND).
- No data transformation; width rule is exact slicing with no padding.

## Timing
- Reset values: state IDLE, idx 0, hold register 0, valid_o 0, busy_o 0, data_o 0, rd_o 0.
- Latency: empty_i falls in cycle n → rd_o high in cycle n → valid_o high with the first beat from cycle n+1.
- Handshake (AXI-style):
  - While valid_o && !ready_i, data_o and valid_o hold stable.
  - valid_o never depends combinationally on ready_i.
- Back-to-back words:
  - Last beat accepted in cycle m with empty_i low → rd_o high in cycle m.
  - First beat of the next word presented in cycle m+1, with no bubble.
  - Throughput is 1 beat/cycle.
- FIFO runs empty:
  - Last beat accepted with empty_i high → IDLE, valid_o low next cycle.
  - rd_o is never asserted while empty_i is high.
- ready_i held high with an empty FIFO: no effect in IDLE.
- Async reset mid-word:
  - Held word is discarded and outputs go to reset values immediately.
  - The FIFO is not re-popped for the lost word.
- rdata_i changing while the FIFO is not being popped: ignored, because the hold register is loaded only on load.

## Structure
- Shared package `fifo_pkg`:
  - state enum type `unpack_state_t` {IDLE, SEND}.
  - localparam helper for word width (RATIO*DATA_WIDTH).
  - idx width via $clog2(RATIO).
- Single module, no sub-module. The slice mux is a simple indexed part-select inside the module.

## Test plan
- Reset then single word: DATA_WIDTH=8, RATIO=2, rdata_i=16'hABCD, empty_i low for one pop, ready_i=1 → one rd_o pulse; beats 8'hAB then 8'hCD on consecutive cycles; valid_o low after.
- Backpressure: same word, ready_i low for 3 cycles after valid_o rises → data_o stays 8'hAB and valid_o stays high for 3 cycles; 8'hCD follows acceptance; exactly one rd_o.
- Streaming: FIFO holds 16'h0102, 16'h0304, 16'h0506, ready_i=1 → beats 01,02,03,04,05,06 on 6 consecutive cycles; rd_o pulses on the cycles beats 02 and 04 are accepted, plus the initial pop.
- MSB_FIRST=0, RATIO=4, rdata_i=32'h11223344 → beats 44,33,22,11.
- Async reset asserted between beats 8'hAB and 8'hCD → valid_o, data_o and rd_o drop to 0 immediately. After release with empty_i high, stays IDLE with no rd_o.
- Empty guard: empty_i high throughout with ready_i toggling → rd_o and valid_o never assert.
